regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_pkg.sv | 8 +
 rtl/regfile_write_arbiter_scoreboard.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 78 +++++++
 tb/tb_regfile_write_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared sizes and requester IDs for the write arbiter.
package regfile_write_arbiter_pkg;
   localparam int RF_WORD_SIZE = 16;
   localparam int RF_NUM_REGS = 4;
   localparam int RF_IDX_W = 2;
   localparam logic [1:0] CNT_MAX = 2'd3;
   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
endpackage

// File: rtl/regfile_write_arbiter_scoreboard.sv
// reg_scoreboard: per-register saturating pending-write counters with sticky error.
module reg_scoreboard
   import regfile_write_arbiter_pkg::*;
#(
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                issue_valid,
   input  logic [RF_IDX_W-1:0] issue_reg,
   input  logic                commit_valid,
   input  logic [RF_IDX_W-1:0] commit_reg,
   output logic [NUM_REGS-1:0] busy,
   output logic                sb_error
);
   logic [NUM_REGS-1:0] w_over;
   logic [NUM_REGS-1:0] w_under;
   logic                r_err;
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
      logic       w_inc;
      logic       w_dec;
      logic [1:0] r_cnt;
      assign w_inc = issue_valid && issue_reg == RF_IDX_W'(i);
      assign w_dec = commit_valid && commit_reg == RF_IDX_W'(i);
      assign w_over[i] = w_inc && !w_dec && r_cnt == CNT_MAX;
      assign w_under[i] = w_dec && !w_inc && r_cnt == 2'd0;
      assign busy[i] = r_cnt != 2'd0;
      // count up on issue, down on commit; simultaneous issue and commit cancel
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) r_cnt <= 2'd0;
         else if (w_inc && !w_dec && !w_over[i]) r_cnt <= r_cnt + 2'd1;
         else if (w_dec && !w_inc && !w_under[i]) r_cnt <= r_cnt - 2'd1;
      end
   end
   // any overflow or underflow latches the error until reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_err <= 1'b0;
      else if (|w_over || |w_under) r_err <= 1'b1;
   end
   assign sb_error = r_err;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-requester round-robin write-port arbiter with pending-write scoreboard.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = RF_WORD_SIZE,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 a_valid,
   input  logic [RF_IDX_W-1:0]  a_reg,
   input  logic [WORD_SIZE-1:0] a_data,
   output logic                 a_ready,
   input  logic                 b_valid,
   input  logic [RF_IDX_W-1:0]  b_reg,
   input  logic [WORD_SIZE-1:0] b_data,
   output logic                 b_ready,
   output logic                 rf_reg_write,
   output logic [RF_IDX_W-1:0]  rf_write_reg,
   output logic [WORD_SIZE-1:0] rf_write_data,
   input  logic                 issue_valid,
   input  logic [RF_IDX_W-1:0]  issue_reg,
   input  logic [RF_IDX_W-1:0]  rd1,
   input  logic [RF_IDX_W-1:0]  rd2,
   output logic                 hazard1,
   output logic                 hazard2,
   output logic [NUM_REGS-1:0]  busy,
   output logic                 sb_error
);
   req_id_t              r_last_grant;
   logic                 r_we;
   logic [RF_IDX_W-1:0]  r_reg;
   logic [WORD_SIZE-1:0] r_data;
   logic                 w_a_xfer;
   logic                 w_b_xfer;
   assign a_ready = reset_n && a_valid && (!b_valid || r_last_grant == REQ_B);
   assign b_ready = reset_n && b_valid && (!a_valid || r_last_grant == REQ_A);
   assign w_a_xfer = a_valid && a_ready;
   assign w_b_xfer = b_valid && b_ready;
   // remember who transferred last so the other side wins the next conflict
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_last_grant <= REQ_B;
      else if (w_a_xfer) r_last_grant <= REQ_A;
      else if (w_b_xfer) r_last_grant <= REQ_B;
   end
   // register the accepted request onto the write port; reg/data hold when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_we <= 1'b0;
         r_reg <= '0;
         r_data <= '0;
      end else begin
         r_we <= w_a_xfer || w_b_xfer;
         if (w_a_xfer) begin
            r_reg <= a_reg;
            r_data <= a_data;
         end else if (w_b_xfer) begin
            r_reg <= b_reg;
            r_data <= b_data;
         end
      end
   end
   assign rf_reg_write = r_we;
   assign rf_write_reg = r_reg;
   assign rf_write_data = r_data;
   reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
      .clk          (clk),
      .reset_n      (reset_n),
      .issue_valid  (issue_valid),
      .issue_reg    (issue_reg),
      .commit_valid (r_we),
      .commit_reg   (r_reg),
      .busy         (busy),
      .sb_error     (sb_error)
   );
   assign hazard1 = busy[rd1];
   assign hazard2 = busy[rd2];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, write latency, scoreboard and reset.
module tb_regfile_write_arbiter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0, issue_valid = 1'b0;
   logic [1:0]  a_reg = '0, b_reg = '0, issue_reg = '0, rd1 = '0, rd2 = '0;
   logic [15:0] a_data = '0, b_data = '0;
   logic        a_ready, b_ready, rf_reg_write, hazard1, hazard2, sb_error;
   logic [1:0]  rf_write_reg;
   logic [15:0] rf_write_data;
   logic [3:0]  busy;
   int          total = 0;
   int          bad = 0;

   regfile_write_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
      .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
      .issue_valid(issue_valid), .issue_reg(issue_reg), .rd1(rd1), .rd2(rd2),
      .hazard1(hazard1), .hazard2(hazard2), .busy(busy), .sb_error(sb_error)
   );

   always #5 clk = ~clk;

   task automatic do_reset;
      reset_n = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
      a_reg = '0; b_reg = '0; issue_reg = '0; rd1 = '0; rd2 = '0; a_data = '0; b_data = '0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1;
      @(negedge clk); #1;
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
      total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_b_ready got=%b exp=0", b_ready); end
      total++; if ({rf_reg_write, rf_write_reg, rf_write_data} !== 19'd0) begin bad++; $display("FAIL reset_wport got=%b/%h/%h exp=0/0/0", rf_reg_write, rf_write_reg, rf_write_data); end
      total++; if ({busy, sb_error, hazard1, hazard2} !== 7'd0) begin bad++; $display("FAIL reset_sb got busy=%b err=%b h=%b%b exp=0", busy, sb_error, hazard1, hazard2); end
   endtask

   task automatic test_single_a;
      do_reset();
      a_valid = 1'b1; a_reg = 2'd2; a_data = 16'h1234; #1;
      total++; if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", {a_ready, b_ready}); end
      @(posedge clk); #1;
      total++; if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd2, 16'h1234}) begin bad++; $display("FAIL single_write got=%b/%h/%h exp=1/2/1234", rf_reg_write, rf_write_reg, rf_write_data); end
      @(negedge clk); a_valid = 1'b0;
      @(posedge clk); #1;
      total++; if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b0, 2'd2, 16'h1234}) begin bad++; $display("FAIL single_hold got=%b/%h/%h exp=0/2/1234", rf_reg_write, rf_write_reg, rf_write_data); end
      total++; if (sb_error !== 1'b1) begin bad++; $display("FAIL single_underflow got=%b exp=1", sb_error); end
   endtask

   task automatic test_conflict;
      do_reset();
      a_valid = 1'b1; a_reg = 2'd1; a_data = 16'hAAAA;
      b_valid = 1'b1; b_reg = 2'd3; b_data = 16'hBBBB; #1;
      total++; if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL conf_g1 got=%b exp=10", {a_ready, b_ready}); end
      @(posedge clk); #1;
      total++; if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd1, 16'hAAAA}) begin bad++; $display("FAIL conf_w1 got=%b/%h/%h exp=1/1/aaaa", rf_reg_write, rf_write_reg, rf_write_data); end
      @(negedge clk); a_reg = 2'd0; a_data = 16'hA002; #1;
      total++; if ({a_ready, b_ready} !== 2'b01) begin bad++; $display("FAIL conf_g2 got=%b exp=01", {a_ready, b_ready}); end
      @(posedge clk); #1;
      total++; if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd3, 16'hBBBB}) begin bad++; $display("FAIL conf_w2 got=%b/%h/%h exp=1/3/bbbb", rf_reg_write, rf_write_reg, rf_write_data); end
      @(negedge clk); b_reg = 2'd2; b_data = 16'hB002; #1;
      total++; if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL conf_g3 got=%b exp=10", {a_ready, b_ready}); end
      @(posedge clk); #1;
      total++; if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd0, 16'hA002}) begin bad++; $display("FAIL conf_w3 got=%b/%h/%h exp=1/0/a002", rf_reg_write, rf_write_reg, rf_write_data); end
      @(negedge clk); a_valid = 1'b0; #1;
      total++; if ({a_ready, b_ready} !== 2'b01) begin bad++; $display("FAIL conf_g4 got=%b exp=01", {a_ready, b_ready}); end
      @(posedge clk); #1;
      total++; if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd2, 16'hB002}) begin bad++; $display("FAIL conf_w4 got=%b/%h/%h exp=1/2/b002", rf_reg_write, rf_write_reg, rf_write_data); end
      @(negedge clk); b_valid = 1'b0;
   endtask

   task automatic test_hazard;
      do_reset();
      issue_valid = 1'b1; issue_reg = 2'd1;
      @(negedge clk);
      @(negedge clk); issue_valid = 1'b0; rd1 = 2'd1; rd2 = 2'd0; #1;
      total++; if ({hazard1, hazard2, busy} !== {1'b1, 1'b0, 4'b0010}) begin bad++; $display("FAIL haz_issue got=%b%b/%b exp=10/0010", hazard1, hazard2, busy); end
      a_valid = 1'b1; a_reg = 2'd1; a_data = 16'h0011;
      @(negedge clk);
      @(negedge clk); a_valid = 1'b0; #1;
      total++; if ({hazard1, busy} !== {1'b1, 4'b0010}) begin bad++; $display("FAIL haz_one_left got=%b/%b exp=1/0010", hazard1, busy); end
      @(negedge clk); #1;
      total++; if ({hazard1, busy, sb_error} !== {1'b0, 4'b0000, 1'b0}) begin bad++; $display("FAIL haz_drained got=%b/%b/%b exp=0/0000/0", hazard1, busy, sb_error); end
   endtask

   task automatic test_same_cycle;
      do_reset();
      issue_valid = 1'b1; issue_reg = 2'd3;
      @(negedge clk); issue_valid = 1'b0; a_valid = 1'b1; a_reg = 2'd3; a_data = 16'h0033;
      @(negedge clk); a_valid = 1'b0; issue_valid = 1'b1; issue_reg = 2'd3; rd2 = 2'd3; #1;
      total++; if (rf_reg_write !== 1'b1) begin bad++; $display("FAIL same_commit_pending got=%b exp=1", rf_reg_write); end
      @(negedge clk); issue_valid = 1'b0; #1;
      total++; if ({busy, hazard2, sb_error} !== {4'b1000, 1'b1, 1'b0}) begin bad++; $display("FAIL same_cycle got=%b/%b/%b exp=1000/1/0", busy, hazard2, sb_error); end
      @(negedge clk); #1;
      total++; if (busy !== 4'b1000) begin bad++; $display("FAIL same_stable got=%b exp=1000", busy); end
   endtask

   task automatic test_saturate;
      do_reset();
      issue_valid = 1'b1; issue_reg = 2'd0;
      repeat (3) @(negedge clk);
      #1;
      total++; if ({busy, sb_error} !== {4'b0001, 1'b0}) begin bad++; $display("FAIL sat_three got=%b/%b exp=0001/0", busy, sb_error); end
      @(negedge clk); issue_valid = 1'b0; #1;
      total++; if ({busy, sb_error} !== {4'b0001, 1'b1}) begin bad++; $display("FAIL sat_four got=%b/%b exp=0001/1", busy, sb_error); end
      a_valid = 1'b1; a_reg = 2'd0; a_data = 16'h0000;
      repeat (3) @(negedge clk);
      a_valid = 1'b0; #1;
      total++; if (busy !== 4'b0001) begin bad++; $display("FAIL sat_after_two got=%b exp=0001", busy); end
      @(negedge clk); #1;
      total++; if ({busy, sb_error} !== {4'b0000, 1'b1}) begin bad++; $display("FAIL sat_drain got=%b/%b exp=0000/1", busy, sb_error); end
      do_reset();
      b_valid = 1'b1; b_reg = 2'd2; b_data = 16'h5A5A; #1;
      total++; if ({a_ready, b_ready} !== 2'b01) begin bad++; $display("FAIL under_ready got=%b exp=01", {a_ready, b_ready}); end
      @(negedge clk); b_valid = 1'b0; #1;
      total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL under_early got=%b exp=0", sb_error); end
      @(negedge clk); #1;
      total++; if ({sb_error, busy} !== {1'b1, 4'b0000}) begin bad++; $display("FAIL under_set got=%b/%b exp=1/0000", sb_error, busy); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      issue_valid = 1'b1; issue_reg = 2'd1;
      @(negedge clk); issue_valid = 1'b0;
      a_valid = 1'b1; a_reg = 2'd2; a_data = 16'hCAFE;
      b_valid = 1'b1; b_reg = 2'd3; b_data = 16'hBEEF;
      @(posedge clk); #2;
      reset_n = 1'b0; #1;
      total++; if ({rf_reg_write, rf_write_reg, rf_write_data} !== 19'd0) begin bad++; $display("FAIL mid_wport got=%b/%h/%h exp=0/0/0", rf_reg_write, rf_write_reg, rf_write_data); end
      total++; if ({busy, sb_error, a_ready, b_ready} !== 7'd0) begin bad++; $display("FAIL mid_state got=%b/%b/%b%b exp=0", busy, sb_error, a_ready, b_ready); end
      @(negedge clk); a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      total++; if (rf_reg_write !== 1'b0) begin bad++; $display("FAIL mid_no_write got=%b exp=0", rf_reg_write); end
      @(negedge clk); a_valid = 1'b1; b_valid = 1'b1; #1;
      total++; if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL mid_prio got=%b exp=10", {a_ready, b_ready}); end
      @(negedge clk); a_valid = 1'b0; b_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_conflict();
      test_hazard();
      test_same_cycle();
      test_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
